// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the riscv_mem stage: memory function codes,
// FSM state encoding and small decode helpers.
package riscv_mem_pkg;

  localparam int MEM_FUNCT_W = 4;

  // Memory function codes carried from EX. Any code not listed is a NOP.
  localparam logic [MEM_FUNCT_W-1:0] MEM_NOP = 4'd0;
  localparam logic [MEM_FUNCT_W-1:0] MEM_LB  = 4'd1;
  localparam logic [MEM_FUNCT_W-1:0] MEM_LH  = 4'd2;
  localparam logic [MEM_FUNCT_W-1:0] MEM_LW  = 4'd3;
  localparam logic [MEM_FUNCT_W-1:0] MEM_LBU = 4'd4;
  localparam logic [MEM_FUNCT_W-1:0] MEM_LHU = 4'd5;
  localparam logic [MEM_FUNCT_W-1:0] MEM_SB  = 4'd6;
  localparam logic [MEM_FUNCT_W-1:0] MEM_SH  = 4'd7;
  localparam logic [MEM_FUNCT_W-1:0] MEM_SW  = 4'd8;

  // Stage FSM: waiting for EX, waiting on the data bus, holding a WB entry.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WB   = 2'd2
  } mem_state_e;

  // True for the five load codes.
  function automatic logic is_load(input logic [MEM_FUNCT_W-1:0] f);
    return (f == MEM_LB) || (f == MEM_LH) || (f == MEM_LW) ||
           (f == MEM_LBU) || (f == MEM_LHU);
  endfunction

  // True for the three store codes.
  function automatic logic is_store(input logic [MEM_FUNCT_W-1:0] f);
    return (f == MEM_SB) || (f == MEM_SH) || (f == MEM_SW);
  endfunction

endpackage

// File: rtl/riscv_mem_align.sv
// Byte-lane alignment for the memory stage. Purely combinational.
// Store side: byte enables and lane-replicated write data.
// Load side: shift the returned word down and sign/zero extend.
// Also flags halfword/word accesses that are not naturally aligned.
module riscv_mem_align
  import riscv_mem_pkg::*;
(
  input  logic [MEM_FUNCT_W-1:0] funct,
  input  logic [1:0]             addr,
  input  logic [31:0]            data,
  input  logic [31:0]            rdata,
  output logic [3:0]             be,
  output logic [31:0]            wdata,
  output logic [31:0]            load_result,
  output logic                   misaligned
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = rdata >> {addr, 3'b000};

  // Decode lanes, extension and alignment for every function code.
  always_comb begin
    be          = 4'b0000;
    wdata       = 32'h0000_0000;
    load_result = 32'h0000_0000;
    misaligned  = 1'b0;
    case (funct)
      MEM_LB: begin
        be          = 4'b1111;
        load_result = {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_LBU: begin
        be          = 4'b1111;
        load_result = {24'h00_0000, shifted[7:0]};
      end
      MEM_LH: begin
        be          = 4'b1111;
        load_result = {{16{shifted[15]}}, shifted[15:0]};
        misaligned  = addr[0];
      end
      MEM_LHU: begin
        be          = 4'b1111;
        load_result = {16'h0000, shifted[15:0]};
        misaligned  = addr[0];
      end
      MEM_LW: begin
        be          = 4'b1111;
        load_result = rdata;
        misaligned  = (addr != 2'b00);
      end
      MEM_SB: begin
        be    = 4'b0001 << addr;
        wdata = {4{data[7:0]}};
      end
      MEM_SH: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr[0];
      end
      MEM_SW: begin
        be         = 4'b1111;
        wdata      = data;
        misaligned = (addr != 2'b00);
      end
      default: begin
        be          = 4'b0000;
        wdata       = 32'h0000_0000;
        load_result = 32'h0000_0000;
        misaligned  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mem.sv
// Memory stage of the danbone RISC-V pipeline.
// Accepts EX results over rdy/ack, runs at most one load/store on the data
// bus, and hands the write-back value to WB over rdy/ack. All outputs are
// registered; the only combinational path is mem_wb_ack -> ex_mem_ack so a
// WB slot can be refilled in the cycle it drains.
module riscv_mem
  import riscv_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_mem_rdy,
  output logic                   ex_mem_ack,
  input  logic [31:0]            ex_mem_result,
  input  logic [MEM_FUNCT_W-1:0] ex_mem_funct,
  input  logic [31:0]            ex_mem_data,
  input  logic [4:0]             ex_mem_wb_rsd,
  output logic                   dbus_req,
  output logic                   dbus_we,
  output logic [31:0]            dbus_addr,
  output logic [3:0]             dbus_be,
  output logic [31:0]            dbus_wdata,
  input  logic                   dbus_ack,
  input  logic [31:0]            dbus_rdata,
  output logic                   mem_wb_rdy,
  input  logic                   mem_wb_ack,
  output logic [31:0]            mem_wb_result,
  output logic [4:0]             mem_wb_rsd,
  output logic                   mem_wb_err
);

  mem_state_e state_r, state_s;

  // Context of the outstanding bus access, needed to shape the load result.
  logic [MEM_FUNCT_W-1:0] funct_r, funct_s;
  logic [1:0]             addr_lo_r, addr_lo_s;
  logic [4:0]             rsd_r, rsd_s;

  // Next values of the registered outputs.
  logic        dbus_req_s, dbus_we_s;
  logic [31:0] dbus_addr_s, dbus_wdata_s;
  logic [3:0]  dbus_be_s;
  logic        mem_wb_rdy_s, mem_wb_err_s;
  logic [31:0] mem_wb_result_s;
  logic [4:0]  mem_wb_rsd_s;

  // Shared aligner: fed from EX when accepting, from the latched access in BUS.
  logic [MEM_FUNCT_W-1:0] al_funct;
  logic [1:0]             al_addr;
  logic [3:0]             al_be;
  logic [31:0]            al_wdata;
  logic [31:0]            al_load;
  logic                   al_mis;

  logic accept;
  logic ex_mem_op;

  // EX may hand over whenever the stage is empty or its WB entry drains now.
  assign ex_mem_ack = (state_r == IDLE) || ((state_r == WB) && mem_wb_ack);
  assign accept     = ex_mem_rdy && ex_mem_ack;
  assign ex_mem_op  = is_load(ex_mem_funct) || is_store(ex_mem_funct);

  assign al_funct = (state_r == BUS) ? funct_r   : ex_mem_funct;
  assign al_addr  = (state_r == BUS) ? addr_lo_r : ex_mem_result[1:0];

  riscv_mem_align u_align (
    .funct       (al_funct),
    .addr        (al_addr),
    .data        (ex_mem_data),
    .rdata       (dbus_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_result (al_load),
    .misaligned  (al_mis)
  );

  // Next-state and next-output decode; everything holds unless changed.
  always_comb begin
    state_s         = state_r;
    funct_s         = funct_r;
    addr_lo_s       = addr_lo_r;
    rsd_s           = rsd_r;
    dbus_req_s      = dbus_req;
    dbus_we_s       = dbus_we;
    dbus_addr_s     = dbus_addr;
    dbus_be_s       = dbus_be;
    dbus_wdata_s    = dbus_wdata;
    mem_wb_rdy_s    = mem_wb_rdy;
    mem_wb_err_s    = mem_wb_err;
    mem_wb_result_s = mem_wb_result;
    mem_wb_rsd_s    = mem_wb_rsd;

    case (state_r)
      IDLE, WB: begin
        if (accept && ex_mem_op && !al_mis) begin
          // Aligned load/store: launch the bus request next cycle.
          state_s      = BUS;
          funct_s      = ex_mem_funct;
          addr_lo_s    = ex_mem_result[1:0];
          rsd_s        = ex_mem_wb_rsd;
          dbus_req_s   = 1'b1;
          dbus_we_s    = is_store(ex_mem_funct);
          dbus_addr_s  = {ex_mem_result[31:2], 2'b00};
          dbus_be_s    = al_be;
          dbus_wdata_s = al_wdata;
          mem_wb_rdy_s = 1'b0;
          mem_wb_err_s = 1'b0;
        end else if (accept && ex_mem_op) begin
          // Misaligned: never touches the bus, reports the faulting address.
          state_s         = WB;
          mem_wb_rdy_s    = 1'b1;
          mem_wb_err_s    = 1'b1;
          mem_wb_rsd_s    = 5'd0;
          mem_wb_result_s = ex_mem_result;
        end else if (accept) begin
          // ALU result (or unknown code): one-cycle pass-through.
          state_s         = WB;
          mem_wb_rdy_s    = 1'b1;
          mem_wb_err_s    = 1'b0;
          mem_wb_rsd_s    = ex_mem_wb_rsd;
          mem_wb_result_s = ex_mem_result;
        end else if ((state_r == WB) && mem_wb_ack) begin
          state_s      = IDLE;
          mem_wb_rdy_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      BUS: begin
        if (dbus_ack) begin
          state_s      = WB;
          dbus_req_s   = 1'b0;
          mem_wb_rdy_s = 1'b1;
          mem_wb_err_s = 1'b0;
          if (is_load(funct_r)) begin
            mem_wb_result_s = al_load;
            mem_wb_rsd_s    = rsd_r;
          end else begin
            mem_wb_result_s = 32'h0000_0000;
            mem_wb_rsd_s    = 5'd0;
          end
        end else begin
          state_s = BUS;
        end
      end
      default: begin
        state_s      = IDLE;
        dbus_req_s   = 1'b0;
        mem_wb_rdy_s = 1'b0;
      end
    endcase
  end

  // State, access context and output registers; reset drops any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      funct_r       <= MEM_NOP;
      addr_lo_r     <= 2'b00;
      rsd_r         <= 5'd0;
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_addr     <= 32'h0000_0000;
      dbus_be       <= 4'b0000;
      dbus_wdata    <= 32'h0000_0000;
      mem_wb_rdy    <= 1'b0;
      mem_wb_err    <= 1'b0;
      mem_wb_result <= 32'h0000_0000;
      mem_wb_rsd    <= 5'd0;
    end else begin
      state_r       <= state_s;
      funct_r       <= funct_s;
      addr_lo_r     <= addr_lo_s;
      rsd_r         <= rsd_s;
      dbus_req      <= dbus_req_s;
      dbus_we       <= dbus_we_s;
      dbus_addr     <= dbus_addr_s;
      dbus_be       <= dbus_be_s;
      dbus_wdata    <= dbus_wdata_s;
      mem_wb_rdy    <= mem_wb_rdy_s;
      mem_wb_err    <= mem_wb_err_s;
      mem_wb_result <= mem_wb_result_s;
      mem_wb_rsd    <= mem_wb_rsd_s;
    end
  end

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: directed steps from the test plan
// followed by random transactions checked against an arithmetic model.
module tb_riscv_mem;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_rdy;
  logic        ex_mem_ack;
  logic [31:0] ex_mem_result;
  logic [3:0]  ex_mem_funct;
  logic [31:0] ex_mem_data;
  logic [4:0]  ex_mem_wb_rsd;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_wb_rdy;
  logic        mem_wb_ack;
  logic [31:0] mem_wb_result;
  logic [4:0]  mem_wb_rsd;
  logic        mem_wb_err;

  int compared   = 0;
  int mismatched = 0;

  riscv_mem dut (
    .clk           (clk),
    .rst           (rst),
    .ex_mem_rdy    (ex_mem_rdy),
    .ex_mem_ack    (ex_mem_ack),
    .ex_mem_result (ex_mem_result),
    .ex_mem_funct  (ex_mem_funct),
    .ex_mem_data   (ex_mem_data),
    .ex_mem_wb_rsd (ex_mem_wb_rsd),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_ack      (dbus_ack),
    .dbus_rdata    (dbus_rdata),
    .mem_wb_rdy    (mem_wb_rdy),
    .mem_wb_ack    (mem_wb_ack),
    .mem_wb_result (mem_wb_result),
    .mem_wb_rsd    (mem_wb_rsd),
    .mem_wb_err    (mem_wb_err)
  );

  always #5 clk = ~clk;

  // Run-length guard.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_load(input logic [3:0] f);
    return f == MEM_LB || f == MEM_LH || f == MEM_LW || f == MEM_LBU || f == MEM_LHU;
  endfunction

  function automatic bit m_store(input logic [3:0] f);
    return f == MEM_SB || f == MEM_SH || f == MEM_SW;
  endfunction

  function automatic int m_size(input logic [3:0] f);
    if (f == MEM_LH || f == MEM_LHU || f == MEM_SH) return 2;
    else if (f == MEM_LW || f == MEM_SW) return 4;
    else return 1;
  endfunction

  function automatic logic [31:0] m_load_val(input logic [3:0] f, input logic [31:0] a,
                                             input logic [31:0] rdata);
    longint w;
    longint v;
    logic [31:0] r;
    w = longint'(rdata);
    v = w / (longint'(1) << (8 * int'(a % 4)));
    if (f == MEM_LB) begin
      v = v % 256;
      if (v >= 128) v = v - 256;
    end else if (f == MEM_LBU) begin
      v = v % 256;
    end else if (f == MEM_LH) begin
      v = v % 65536;
      if (v >= 32768) v = v - 65536;
    end else if (f == MEM_LHU) begin
      v = v % 65536;
    end else begin
      v = w;
    end
    r = 32'(v);
    return r;
  endfunction

  function automatic logic [31:0] m_be(input logic [3:0] f, input logic [31:0] a);
    if (f == MEM_SB) return 32'(1 << int'(a % 4));
    else if (f == MEM_SH) return (a % 4 >= 2) ? 32'd12 : 32'd3;
    else return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] f, input logic [31:0] d);
    if (f == MEM_SB) return (d % 256) * 32'h0101_0101;
    else if (f == MEM_SH) return (d % 65536) * 32'h0001_0001;
    else return d;
  endfunction

  // One complete transaction from IDLE, entered and left on a falling edge.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd,
                        input logic [31:0] rdata, input int waits);
    bit ld, st, mis;
    logic [31:0] exp_res;
    logic [4:0]  exp_rd;
    logic        exp_err;
    ld  = m_load(f);
    st  = m_store(f);
    mis = (ld || st) && ((a % m_size(f)) != 0);
    ex_mem_rdy = 1'b1; ex_mem_funct = f; ex_mem_result = a;
    ex_mem_data = d; ex_mem_wb_rsd = rd; mem_wb_ack = 1'b0;
    #1 chk({tag, "/ex_ack_idle"}, ex_mem_ack, 1);
    @(posedge clk); @(negedge clk);
    ex_mem_rdy = 1'b0;
    if ((ld || st) && !mis) begin
      chk({tag, "/req"}, dbus_req, 1);
      chk({tag, "/we"}, dbus_we, st);
      chk({tag, "/addr"}, dbus_addr, a & 32'hFFFF_FFFC);
      chk({tag, "/be"}, dbus_be, m_be(f, a));
      if (st) chk({tag, "/wdata"}, dbus_wdata, m_wdata(f, d));
      chk({tag, "/ex_ack_bus"}, ex_mem_ack, 0);
      for (int i = 0; i < waits; i++) begin
        dbus_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        chk({tag, "/req_held"}, dbus_req, 1);
        chk({tag, "/addr_held"}, dbus_addr, a & 32'hFFFF_FFFC);
        chk({tag, "/be_held"}, dbus_be, m_be(f, a));
        chk({tag, "/wb_rdy_bus"}, mem_wb_rdy, 0);
        chk({tag, "/ex_ack_wait"}, ex_mem_ack, 0);
      end
      dbus_ack = 1'b1; dbus_rdata = rdata;
      @(posedge clk); @(negedge clk);
      dbus_ack = 1'b0; dbus_rdata = $urandom;
      exp_res = ld ? m_load_val(f, a, rdata) : 32'h0;
      exp_rd  = ld ? rd : 5'd0;
      exp_err = 1'b0;
    end else begin
      exp_res = a;
      exp_rd  = mis ? 5'd0 : rd;
      exp_err = mis;
    end
    chk({tag, "/req_done"}, dbus_req, 0);
    chk({tag, "/wb_rdy"}, mem_wb_rdy, 1);
    chk({tag, "/wb_rsd"}, mem_wb_rsd, exp_rd);
    chk({tag, "/wb_err"}, mem_wb_err, exp_err);
    if (!st || mis) chk({tag, "/wb_result"}, mem_wb_result, exp_res);
    mem_wb_ack = 1'b1;
    #1 chk({tag, "/ex_ack_wb"}, ex_mem_ack, 1);
    @(posedge clk); @(negedge clk);
    mem_wb_ack = 1'b0;
    chk({tag, "/drained"}, mem_wb_rdy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  rf;
    logic [31:0] ra;
    rst = 1'b1; ex_mem_rdy = 1'b0; ex_mem_result = 32'h0; ex_mem_funct = MEM_NOP;
    ex_mem_data = 32'h0; ex_mem_wb_rsd = 5'd0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    mem_wb_ack = 1'b0;

    // Reset state.
    #2;
    chk("rst/req", dbus_req, 0);
    chk("rst/we", dbus_we, 0);
    chk("rst/addr", dbus_addr, 0);
    chk("rst/be", dbus_be, 0);
    chk("rst/wdata", dbus_wdata, 0);
    chk("rst/wb_rdy", mem_wb_rdy, 0);
    chk("rst/wb_result", mem_wb_result, 0);
    chk("rst/wb_rsd", mem_wb_rsd, 0);
    chk("rst/wb_err", mem_wb_err, 0);
    chk("rst/ex_ack", ex_mem_ack, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single pass-through.
    run_op("nop", MEM_NOP, 32'h1234_5678, 32'h0, 5'd5, 32'h0, 0);

    // Back-to-back pass-through at one per cycle.
    mem_wb_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex_mem_rdy = 1'b1; ex_mem_funct = MEM_NOP;
      ex_mem_result = 32'h1234_5678 + 32'(i); ex_mem_wb_rsd = 5'(5 + i);
      #1 chk("b2b/ex_ack", ex_mem_ack, 1);
      if (i > 0) begin
        chk("b2b/rdy", mem_wb_rdy, 1);
        chk("b2b/result", mem_wb_result, 32'h1234_5678 + 32'(i - 1));
        chk("b2b/rsd", mem_wb_rsd, 32'(5 + i - 1));
      end
      chk("b2b/no_req", dbus_req, 0);
      @(posedge clk); @(negedge clk);
    end
    ex_mem_rdy = 1'b0;
    chk("b2b/last", mem_wb_result, 32'h1234_567C);
    @(posedge clk); @(negedge clk);
    mem_wb_ack = 1'b0;
    chk("b2b/drained", mem_wb_rdy, 0);

    // Loads with three wait cycles.
    run_op("lb",  MEM_LB,  32'h103, 32'h0, 5'd1, 32'h80FF_7F01, 3);
    run_op("lbu", MEM_LBU, 32'h103, 32'h0, 5'd2, 32'h80FF_7F01, 3);
    run_op("lh",  MEM_LH,  32'h102, 32'h0, 5'd3, 32'h80FF_7F01, 3);
    run_op("lhu", MEM_LHU, 32'h102, 32'h0, 5'd4, 32'h80FF_7F01, 3);
    run_op("lw",  MEM_LW,  32'h100, 32'h0, 5'd6, 32'h80FF_7F01, 3);
    chk("lb/value", m_load_val(MEM_LB, 32'h103, 32'h80FF_7F01), 32'hFFFF_FF80);

    // Stores.
    run_op("sb", MEM_SB, 32'h201, 32'hAABB_CCDD, 5'd7, 32'h0, 0);
    run_op("sh", MEM_SH, 32'h202, 32'hAABB_CCDD, 5'd8, 32'h0, 1);
    run_op("sw", MEM_SW, 32'h204, 32'hAABB_CCDD, 5'd9, 32'h0, 2);

    // Misaligned.
    run_op("lw_mis", MEM_LW, 32'h101, 32'h0, 5'd10, 32'h0, 0);
    run_op("sh_mis", MEM_SH, 32'h103, 32'h0, 5'd11, 32'h0, 0);

    // Stray bus ack while idle is ignored.
    dbus_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dbus_ack = 1'b0;
    chk("stray/wb_rdy", mem_wb_rdy, 0);
    chk("stray/req", dbus_req, 0);
    chk("stray/ex_ack", ex_mem_ack, 1);

    // Backpressure from WB.
    ex_mem_rdy = 1'b1; ex_mem_funct = MEM_NOP; ex_mem_result = 32'hA0A0_0001;
    ex_mem_wb_rsd = 5'd7; mem_wb_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_mem_result = 32'hB0B0_0002; ex_mem_wb_rsd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp/ex_ack", ex_mem_ack, 0);
      chk("bp/rdy", mem_wb_rdy, 1);
      chk("bp/result", mem_wb_result, 32'hA0A0_0001);
      chk("bp/rsd", mem_wb_rsd, 7);
      @(posedge clk); @(negedge clk);
    end
    mem_wb_ack = 1'b1;
    #1 chk("bp/ex_ack_pulse", ex_mem_ack, 1);
    @(posedge clk); @(negedge clk);
    ex_mem_rdy = 1'b0; mem_wb_ack = 1'b0;
    chk("bp/next_rdy", mem_wb_rdy, 1);
    chk("bp/next_result", mem_wb_result, 32'hB0B0_0002);
    chk("bp/next_rsd", mem_wb_rsd, 9);
    mem_wb_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_wb_ack = 1'b0;
    chk("bp/no_dup", mem_wb_rdy, 0);

    // Reset in the middle of a bus access.
    ex_mem_rdy = 1'b1; ex_mem_funct = MEM_LW; ex_mem_result = 32'h300; ex_mem_wb_rsd = 5'd3;
    @(posedge clk); @(negedge clk);
    ex_mem_rdy = 1'b0;
    chk("rbus/req_before", dbus_req, 1);
    rst = 1'b1;
    #1;
    chk("rbus/req", dbus_req, 0);
    chk("rbus/wb_rdy", mem_wb_rdy, 0);
    chk("rbus/ex_ack", ex_mem_ack, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("rbus_nop", MEM_NOP, 32'hCAFE_0001, 32'h0, 5'd12, 32'h0, 0);

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      rf = 4'($urandom_range(0, 15));
      ra = 32'h400 + 32'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", n), rf, ra, $urandom, 5'($urandom_range(0, 31)),
             $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
